// File: rtl/pc_sequencer.sv
// IF-stage program counter sequencer: picks sequential, redirect or held PC and drives the fetch request.
// Optional build macro PC_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR and raises MISALIGN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        FLUSH,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        REDIR_PEND = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] pend_q, pend_next;
    logic        flush_q, flush_next;
    logic        mis_q, mis_next;

    logic [31:0] redir_src;
    logic [31:0] redir_pc;
    logic        redir_mis;

    // A pending redirect uses the latched target; a direct one uses the live EX target.
    assign redir_src = (state == REDIR_PEND) ? pend_q : BRANCH_TARGET;

`ifdef PC_MISALIGN_TRAP_EN
    always_comb begin
        redir_pc  = redir_src;
        redir_mis = 1'b0;
        if (redir_src[1:0] != 2'b00) begin
            redir_pc  = TRAP_VECTOR;
            redir_mis = 1'b1;
        end
    end
`else
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
    assign redir_pc  = redir_src;
    assign redir_mis = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        pend_next  = pend_q;
        flush_next = 1'b0;
        mis_next   = 1'b0;
        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (BRANCH_TAKEN) begin
                    if (IMEM_BUSYWAIT) begin
                        // Never abort an in-flight read; finish the redirect once it completes.
                        pend_next  = BRANCH_TARGET;
                        state_next = REDIR_PEND;
                    end else begin
                        pc_next    = redir_pc;
                        flush_next = 1'b1;
                        mis_next   = redir_mis;
                    end
                end else if (!STALL && !IMEM_BUSYWAIT) begin
                    pc_next = PC_PLUS4;
                end
            end
            REDIR_PEND: begin
                if (!IMEM_BUSYWAIT) begin
                    pc_next    = redir_pc;
                    flush_next = 1'b1;
                    mis_next   = redir_mis;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            pend_q  <= 32'h0000_0000;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            pend_q  <= pend_next;
            flush_q <= flush_next;
            mis_q   <= mis_next;
        end
    end

    assign PC        = pc_q;
    assign PC_PLUS4  = pc_q + 32'd4;
    assign IMEM_READ = (state != BOOT);
    assign FLUSH     = flush_q;
    assign MISALIGN  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        busy = 1'b0;
    logic        imem_read;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: where the fetch stream is, and any redirect still waiting on memory.
    logic [31:0] m_pc = RV;
    bit          m_boot = 1'b1;
    bit          m_pending = 1'b0;
    logic [31:0] m_pend_tgt = 32'h0;
    bit          m_flush = 1'b0;
    bit          m_mis = 1'b0;

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .CLK(clk),
        .RESET(rst),
        .STALL(stall),
        .BRANCH_TAKEN(br),
        .BRANCH_TARGET(tgt),
        .IMEM_BUSYWAIT(busy),
        .IMEM_READ(imem_read),
        .PC(pc),
        .PC_PLUS4(pc_plus4),
        .FLUSH(flush),
        .MISALIGN(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic take_redirect(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        if (t % 4 != 0) begin
            m_pc  = TV;
            m_mis = 1'b1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t;
`endif
        m_flush = 1'b1;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic b,
                              input logic [31:0] t, input logic bz);
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (r) begin
            m_pc      = RV;
            m_boot    = 1'b1;
            m_pending = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pending) begin
            if (!bz) begin
                take_redirect(m_pend_tgt);
                m_pending = 1'b0;
            end
        end else if (b) begin
            if (bz) begin
                m_pending  = 1'b1;
                m_pend_tgt = t;
            end else begin
                take_redirect(t);
            end
        end else if (!s && !bz) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic bz);
        @(negedge clk);
        rst   = r;
        stall = s;
        br    = b;
        tgt   = t;
        busy  = bz;
        @(posedge clk);
        model_edge(r, s, b, t, bz);
        #1;
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, "_read"}, {31'b0, imem_read}, {31'b0, !m_boot});
        chk({tag, "_flush"}, {31'b0, flush}, {31'b0, m_flush});
        chk({tag, "_mis"}, {31'b0, misalign}, {31'b0, m_mis});
    endtask

    initial begin
        // 1. reset, boot bubble, sequential fetch
        step("rst0", 1, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0);
        chk("t1_read_in_reset", {31'b0, imem_read}, 32'd0);
        step("boot", 0, 0, 0, 0, 0);
        chk("t1_pc_boot", pc, 32'h0);
        step("seq4", 0, 0, 0, 0, 0);
        chk("t1_pc_4", pc, 32'h4);
        step("seq8", 0, 0, 0, 0, 0);
        step("seqc", 0, 0, 0, 0, 0);
        chk("t1_pc_c", pc, 32'hC);
        step("seq10", 0, 0, 0, 0, 0);
        chk("t1_pc_10", pc, 32'h10);

        // 2. taken branch from 0x10
        step("br40", 0, 0, 1, 32'h40, 0);
        chk("t2_pc_40", pc, 32'h40);
        chk("t2_flush", {31'b0, flush}, 32'd1);
        step("br44", 0, 0, 0, 0, 0);
        chk("t2_pc_44", pc, 32'h44);
        chk("t2_flush_low", {31'b0, flush}, 32'd0);

        // 3. branch during busywait at 0x20
        step("to1c", 0, 0, 1, 32'h1C, 0);
        step("to20", 0, 0, 0, 0, 0);
        chk("t3_pc_20", pc, 32'h20);
        step("busy0", 0, 0, 1, 32'h80, 1);
        step("busy1", 0, 0, 0, 0, 1);
        step("busy2", 0, 0, 0, 0, 1);
        chk("t3_hold_20", pc, 32'h20);
        step("busyend", 0, 0, 0, 0, 0);
        chk("t3_pc_80", pc, 32'h80);
        chk("t3_flush", {31'b0, flush}, 32'd1);

        // 4. stall hold, then stall + branch
        step("to30", 0, 0, 1, 32'h30, 0);
        step("stall0", 0, 1, 0, 0, 0);
        step("stall1", 0, 1, 0, 0, 0);
        chk("t4_hold_30", pc, 32'h30);
        step("unstall", 0, 0, 0, 0, 0);
        chk("t4_pc_34", pc, 32'h34);
        step("stallbr", 0, 1, 1, 32'h100, 0);
        chk("t4_pc_100", pc, 32'h100);

        // 5. wrap and reset during pending redirect
        step("tomax", 0, 0, 1, 32'hFFFF_FFFC, 0);
        chk("t5_pc4_wrap", pc_plus4, 32'h0);
        step("wrap", 0, 0, 0, 0, 0);
        chk("t5_pc_0", pc, 32'h0);
        step("pend", 0, 0, 1, 32'h200, 1);
        step("rstpend", 1, 0, 0, 0, 1);
        chk("t5_rst_flush", {31'b0, flush}, 32'd0);
        chk("t5_rst_read", {31'b0, imem_read}, 32'd0);
        step("boot2", 0, 0, 0, 0, 0);
        step("run2", 0, 0, 0, 0, 0);
        chk("t5_after_rst", pc, 32'h4);

        // 6. misaligned targets, direct and via pending path
        step("mis42", 0, 0, 1, 32'h42, 0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("t6_pc", pc, TV);
        chk("t6_mis", {31'b0, misalign}, 32'd1);
`else
        chk("t6_pc", pc, 32'h42);
        chk("t6_mis", {31'b0, misalign}, 32'd0);
`endif
        step("realign", 0, 0, 1, 32'h500, 0);
        step("mispend", 0, 0, 1, 32'h603, 1);
        step("mispend_done", 0, 0, 0, 0, 0);

        // random traffic; branch held low while a redirect is pending
        for (int i = 0; i < 400; i++) begin
            logic        r, s, b, bz;
            logic [31:0] t;
            r  = ($urandom_range(0, 49) == 0);
            bz = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 3) == 0);
            b  = !m_pending && ($urandom_range(0, 4) == 0);
            t  = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
            step("rnd", r, s, b, t, bz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
